// File: rtl/monitor_bus_master.sv
// Purpose: reads a burst of consecutive card-bus slave words and streams each captured word out on rd_data/rd_valid.
// Latency: 4 cycles per word minimum (SEL, WAIT_ACK, HOLD, RELEASE) plus one DONE cycle that ends the burst.
// Backpressure: stays in HOLD with CARD_SEL and rd_data held until rd_ready; each ack phase aborts after TIMEOUT cycles.
module monitor_bus_master #(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int CNT_W   = 6,
    parameter int TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [CNT_W-1:0] burst_len,
    output logic             CARD_SEL,
    output logic [AW-1:0]    AI,
    output logic             WR_IN_N,
    input  logic             SACK_N,
    input  logic [DW-1:0]    SDO,
    output logic [DW-1:0]    rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int              TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        WAIT_ACK,
        HOLD,
        RELEASE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] remaining;
    logic [TW-1:0]    timer;
    logic [AW-1:0]    ai_q;
    logic [DW-1:0]    data_q;
    logic             valid_q;
    logic             err_q;

    logic start_acc;
    logic ld_cmd;
    logic capture;
    logic handshake;
    logic advance;
    logic tmr_inc;
    logic tmo;

    // State register; reset drops any burst in flight without a done pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and one-cycle datapath strobes.
    always_comb begin
        state_n   = state;
        start_acc = 1'b0;
        ld_cmd    = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        advance   = 1'b0;
        tmr_inc   = 1'b0;
        tmo       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    if (burst_len != '0) begin
                        ld_cmd  = 1'b1;
                        state_n = SEL;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            SEL: begin
                state_n = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!SACK_N) begin
                    capture = 1'b1;
                    state_n = HOLD;
                end else if (timer == T_LAST) begin
                    tmo     = 1'b1;
                    state_n = DONE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            HOLD: begin
                if (valid_q && rd_ready) begin
                    handshake = 1'b1;
                    state_n   = RELEASE;
                end
            end
            RELEASE: begin
                if (SACK_N) begin
                    if (remaining == '0) begin
                        state_n = DONE;
                    end else begin
                        advance = 1'b1;
                        state_n = SEL;
                    end
                end else if (timer == T_LAST) begin
                    tmo     = 1'b1;
                    state_n = DONE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Address, word counter, ack timer, captured word and sticky error flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ai_q      <= '0;
            remaining <= '0;
            timer     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (start_acc) begin
                err_q <= 1'b0;
            end
            if (ld_cmd) begin
                ai_q      <= base_addr;
                remaining <= burst_len;
            end
            if (advance) begin
                ai_q <= ai_q + 1'b1;
            end
            // Timer restarts for each ack phase: entering WAIT_ACK (from SEL) and entering RELEASE.
            if (state == SEL || handshake) begin
                timer <= '0;
            end else if (tmr_inc) begin
                timer <= timer + 1'b1;
            end
            if (capture) begin
                data_q  <= SDO;
                valid_q <= 1'b1;
            end
            if (handshake) begin
                valid_q   <= 1'b0;
                remaining <= remaining - 1'b1;
            end
            if (tmo) begin
                err_q <= 1'b1;
            end
        end
    end

    // Select is held through HOLD so the slave keeps its ack until the word is consumed.
    assign CARD_SEL = (state == SEL) || (state == WAIT_ACK) || (state == HOLD);
    assign AI       = ai_q;
    assign WR_IN_N  = 1'b1;
    assign rd_data  = data_q;
    assign rd_valid = valid_q;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign err      = err_q;

endmodule

// File: tb/tb_monitor_bus_master.sv
// Bench for monitor_bus_master: behavioural card-bus slave, stream consumer and burst reference model.
// Each test task drives one scenario and compares observed outputs against expectations computed here.
// Monitor and driver processes each own their variables; the main sequence only reads monitor state.
module tb_monitor_bus_master;
    localparam int AW      = 10;
    localparam int DW      = 32;
    localparam int CNT_W   = 6;
    localparam int TIMEOUT = 255;
    localparam logic [AW-1:0] ID_ADDR   = 10'h3F0;
    localparam logic [15:0]   ID_STATUS = 16'h5A3C;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [CNT_W-1:0] burst_len;
    logic             CARD_SEL;
    logic [AW-1:0]    AI;
    logic             WR_IN_N;
    logic             SACK_N;
    logic [DW-1:0]    SDO;
    logic [DW-1:0]    rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic             busy;
    logic             done;
    logic             err;

    int n_checks = 0;
    int n_pass   = 0;

    // Slave and consumer controls, written only by the main sequence.
    int   ack_delay;
    int   rel_delay;
    bit   slave_mute;
    int   ready_mode;   // 0 = always ready, 1 = random, 2 = held low
    logic [DW-1:0] mem [0:1023];

    // Monitor results, written only by the monitor process.
    int done_cnt    = 0;
    int valid_seen  = 0;
    int sel_seen    = 0;
    int wr_low_seen = 0;
    logic [DW-1:0] got_data[$];
    logic [AW-1:0] got_addr[$];

    monitor_bus_master #(.AW(AW), .DW(DW), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .base_addr(base_addr), .burst_len(burst_len),
        .CARD_SEL(CARD_SEL), .AI(AI), .WR_IN_N(WR_IN_N), .SACK_N(SACK_N), .SDO(SDO),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    // Behavioural slave: acks ack_delay cycles after select rises, releases rel_delay cycles after it falls.
    initial begin
        int sel_cnt;
        int rel_cnt;
        SACK_N  = 1'b1;
        SDO     = '0;
        sel_cnt = 0;
        rel_cnt = 0;
        forever begin
            @(posedge CLK); #1;
            if (CARD_SEL === 1'b1) begin
                rel_cnt = 0;
                if (!slave_mute && sel_cnt >= ack_delay) begin
                    SACK_N = 1'b0;
                    SDO    = mem[AI];
                end else begin
                    SACK_N = 1'b1;
                    SDO    = $urandom;
                end
                sel_cnt++;
            end else begin
                sel_cnt = 0;
                if (SACK_N === 1'b0) begin
                    if (rel_cnt >= rel_delay) begin
                        SACK_N = 1'b1;
                        SDO    = $urandom;
                    end
                    rel_cnt++;
                end else begin
                    SDO = $urandom;
                end
            end
        end
    end

    // Stream consumer.
    initial begin
        rd_ready = 1'b0;
        forever begin
            @(posedge CLK); #1;
            case (ready_mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = 1'($urandom_range(0, 1));
                default: rd_ready = 1'b0;
            endcase
        end
    end

    // Monitor: records accepted words and counts events, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge CLK);
            if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
                got_data.push_back(rd_data);
                got_addr.push_back(AI);
            end
            if (done === 1'b1)     done_cnt++;
            if (rd_valid === 1'b1) valid_seen++;
            if (CARD_SEL === 1'b1) sel_seen++;
            if (WR_IN_N !== 1'b1)  wr_low_seen++;
        end
    end

    // Reference model: word i of a burst comes from address (base + i) modulo 2^AW.
    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int i);
        return AW'((int'(base) + i) % (1 << AW));
    endfunction

    function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] base, input int i);
        return mem[exp_addr(base, i)];
    endfunction

    task automatic do_start(input logic [AW-1:0] base, input int len);
        @(posedge CLK); #1;
        start     = 1'b1;
        base_addr = base;
        burst_len = CNT_W'(len);
        @(posedge CLK); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output int ncyc);
        ok   = 1'b0;
        ncyc = 0;
        while (ncyc < budget && !ok) begin
            @(negedge CLK);
            ncyc++;
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_checks++; if (CARD_SEL !== 1'b0) $display("FAIL reset_card_sel got=%b exp=0", CARD_SEL); else n_pass++;
        n_checks++; if (AI !== '0) $display("FAIL reset_ai got=%h exp=0", AI); else n_pass++;
        n_checks++; if (WR_IN_N !== 1'b1) $display("FAIL reset_wr_in_n got=%b exp=1", WR_IN_N); else n_pass++;
        n_checks++; if (rd_data !== '0) $display("FAIL reset_rd_data got=%h exp=0", rd_data); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
        @(posedge CLK); #1;
        RESET = 1'b0;
    endtask

    task automatic test_burst();
        int n0, d0, w0, nc;
        bit ok;
        ack_delay = 2; rel_delay = 1; ready_mode = 0;
        n0 = got_data.size(); d0 = done_cnt; w0 = wr_low_seen;
        do_start(10'h000, 4);
        wait_done(200, ok, nc);
        #1;
        n_checks++; if (!ok) $display("FAIL burst_done_timeout got=none exp=done"); else n_pass++;
        n_checks++; if (got_data.size() - n0 != 4) $display("FAIL burst_count got=%0d exp=4", got_data.size() - n0); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (got_data[n0+i] !== 32'hA0 + i) $display("FAIL burst_data[%0d] got=%h exp=%h", i, got_data[n0+i], 32'hA0 + i); else n_pass++;
            n_checks++; if (got_addr[n0+i] !== AW'(i)) $display("FAIL burst_addr[%0d] got=%h exp=%h", i, got_addr[n0+i], i); else n_pass++;
        end
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL burst_done_pulses got=%0d exp=1", done_cnt - d0); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL burst_err got=%b exp=0", err); else n_pass++;
        n_checks++; if (wr_low_seen != w0) $display("FAIL burst_wr_in_n_low got=%0d exp=%0d", wr_low_seen, w0); else n_pass++;
    endtask

    task automatic test_throughput();
        int nc;
        bit ok;
        ack_delay = 0; rel_delay = 0; ready_mode = 0;
        do_start(AW'($urandom_range(0, 1023)), 5);
        wait_done(100, ok, nc);
        n_checks++; if (!ok || nc != 4 * 5 + 1) $display("FAIL throughput_cycles got=%0d exp=%0d", nc, 4 * 5 + 1); else n_pass++;
    endtask

    task automatic test_backpressure();
        int n0, d0, nc;
        bit ok;
        logic [AW-1:0] base;
        base = AW'(10'h100 + $urandom_range(0, 255));
        ack_delay = 1; rel_delay = 0; ready_mode = 2;
        n0 = got_data.size(); d0 = done_cnt;
        do_start(base, 2);
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge CLK);
            if (rd_valid === 1'b1) ok = 1'b1;
        end
        n_checks++; if (!ok) $display("FAIL bp_valid_timeout got=none exp=rd_valid"); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            n_checks++; if (rd_valid !== 1'b1) $display("FAIL bp_valid_hold c%0d got=%b exp=1", c, rd_valid); else n_pass++;
            n_checks++; if (rd_data !== exp_word(base, 0)) $display("FAIL bp_data_hold c%0d got=%h exp=%h", c, rd_data, exp_word(base, 0)); else n_pass++;
            n_checks++; if (CARD_SEL !== 1'b1) $display("FAIL bp_card_sel_hold c%0d got=%b exp=1", c, CARD_SEL); else n_pass++;
            n_checks++; if (AI !== base) $display("FAIL bp_ai_hold c%0d got=%h exp=%h", c, AI, base); else n_pass++;
        end
        ready_mode = 0;
        wait_done(100, ok, nc);
        #1;
        n_checks++; if (!ok) $display("FAIL bp_done_timeout got=none exp=done"); else n_pass++;
        n_checks++; if (got_data.size() - n0 != 2) $display("FAIL bp_count got=%0d exp=2", got_data.size() - n0); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (got_data[n0+i] !== exp_word(base, i)) $display("FAIL bp_data[%0d] got=%h exp=%h", i, got_data[n0+i], exp_word(base, i)); else n_pass++;
        end
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL bp_done_pulses got=%0d exp=1", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_timeout();
        int d0, v0, n0, sel, nc;
        bit ok;
        logic [AW-1:0] base;
        base = AW'($urandom_range(0, 1023));
        slave_mute = 1'b1; ready_mode = 0;
        d0 = done_cnt; v0 = valid_seen;
        do_start(base, 3);
        sel = 0; ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge CLK);
            if (done === 1'b1) ok = 1'b1;
            else if (CARD_SEL === 1'b1) sel++;
        end
        #1;
        n_checks++; if (!ok) $display("FAIL tmo_done_timeout got=none exp=done"); else n_pass++;
        n_checks++; if (sel != 1 + TIMEOUT) $display("FAIL tmo_sel_cycles got=%0d exp=%0d", sel, 1 + TIMEOUT); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL tmo_err got=%b exp=1", err); else n_pass++;
        n_checks++; if (valid_seen != v0) $display("FAIL tmo_rd_valid got=%0d exp=%0d", valid_seen, v0); else n_pass++;
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL tmo_done_pulses got=%0d exp=1", done_cnt - d0); else n_pass++;
        repeat (3) @(negedge CLK);
        n_checks++; if (err !== 1'b1) $display("FAIL tmo_err_sticky got=%b exp=1", err); else n_pass++;
        slave_mute = 1'b0; ack_delay = 0; rel_delay = 0;
        n0 = got_data.size();
        do_start(base, 1);
        @(negedge CLK);
        n_checks++; if (err !== 1'b0) $display("FAIL tmo_err_clear got=%b exp=0", err); else n_pass++;
        wait_done(50, ok, nc);
        #1;
        n_checks++; if (!ok || got_data.size() - n0 != 1 || got_data[n0] !== exp_word(base, 0))
            $display("FAIL tmo_recover_word got=%h exp=%h", got_data[n0], exp_word(base, 0)); else n_pass++;
    endtask

    task automatic test_wrap_id();
        int n0, nc;
        bit ok;
        ack_delay = int'($urandom_range(0, 3)); rel_delay = int'($urandom_range(0, 2)); ready_mode = 1;
        n0 = got_data.size();
        do_start(10'h3FF, 2);
        wait_done(100, ok, nc);
        #1;
        n_checks++; if (!ok || got_data.size() - n0 != 2) $display("FAIL wrap_count got=%0d exp=2", got_data.size() - n0); else n_pass++;
        n_checks++; if (got_addr[n0] !== 10'h3FF) $display("FAIL wrap_addr0 got=%h exp=3ff", got_addr[n0]); else n_pass++;
        n_checks++; if (got_addr[n0+1] !== 10'h000) $display("FAIL wrap_addr1 got=%h exp=000", got_addr[n0+1]); else n_pass++;
        n_checks++; if (got_data[n0+1] !== exp_word(10'h3FF, 1)) $display("FAIL wrap_data1 got=%h exp=%h", got_data[n0+1], exp_word(10'h3FF, 1)); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL wrap_err got=%b exp=0", err); else n_pass++;
        n0 = got_data.size();
        do_start(ID_ADDR, 1);
        wait_done(100, ok, nc);
        #1;
        n_checks++; if (!ok || got_data[n0] !== 32'h0000_5A3C) $display("FAIL id_word got=%h exp=00005a3c", got_data[n0]); else n_pass++;
    endtask

    task automatic test_zero_len();
        int s0, d0;
        s0 = sel_seen; d0 = done_cnt;
        do_start(AW'($urandom_range(0, 1023)), 0);
        @(negedge CLK);
        n_checks++; if (done !== 1'b1) $display("FAIL zero_done got=%b exp=1", done); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL zero_busy got=%b exp=1", busy); else n_pass++;
        @(negedge CLK);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL zero_idle got=%b%b exp=00", done, busy); else n_pass++;
        #1;
        n_checks++; if (sel_seen != s0) $display("FAIL zero_card_sel got=%0d exp=%0d", sel_seen, s0); else n_pass++;
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL zero_done_pulses got=%0d exp=1", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_start_while_busy();
        int n0, d0, nc;
        bit ok;
        logic [AW-1:0] base;
        base = AW'($urandom_range(0, 1023));
        ack_delay = 1; rel_delay = 1; ready_mode = 1;
        n0 = got_data.size(); d0 = done_cnt;
        do_start(base, 3);
        repeat (3) @(posedge CLK);
        #1;
        start = 1'b1; base_addr = ~base; burst_len = 6'd7;
        @(posedge CLK); #1;
        start = 1'b0;
        wait_done(300, ok, nc);
        repeat (3) @(negedge CLK);
        #1;
        n_checks++; if (!ok || got_data.size() - n0 != 3) $display("FAIL busy_start_count got=%0d exp=3", got_data.size() - n0); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (got_addr[n0+i] !== exp_addr(base, i)) $display("FAIL busy_start_addr[%0d] got=%h exp=%h", i, got_addr[n0+i], exp_addr(base, i)); else n_pass++;
        end
        n_checks++; if (done_cnt - d0 != 1 || busy !== 1'b0) $display("FAIL busy_start_done got=%0d exp=1", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int d0;
        slave_mute = 1'b1; ready_mode = 0;
        do_start(AW'($urandom_range(1, 1023)), 4);
        repeat (5) @(negedge CLK);
        n_checks++; if (busy !== 1'b1 || CARD_SEL !== 1'b1) $display("FAIL rst_mid_pre got=%b%b exp=11", busy, CARD_SEL); else n_pass++;
        #1;
        d0 = done_cnt;
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        n_checks++; if (CARD_SEL !== 1'b0) $display("FAIL rst_mid_card_sel got=%b exp=0", CARD_SEL); else n_pass++;
        n_checks++; if (AI !== '0) $display("FAIL rst_mid_ai got=%h exp=0", AI); else n_pass++;
        n_checks++; if (rd_data !== '0 || rd_valid !== 1'b0) $display("FAIL rst_mid_rd got=%h/%b exp=0/0", rd_data, rd_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) $display("FAIL rst_mid_status got=%b%b%b exp=000", busy, done, err); else n_pass++;
        @(posedge CLK); #1;
        RESET = 1'b0;
        slave_mute = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        n_checks++; if (done_cnt != d0) $display("FAIL rst_mid_no_done got=%0d exp=%0d", done_cnt, d0); else n_pass++;
    endtask

    task automatic test_random();
        int n0, d0, nc, len;
        bit ok;
        logic [AW-1:0] base;
        for (int it = 0; it < 25; it++) begin
            base = AW'($urandom_range(0, 1023));
            len  = int'($urandom_range(1, 8));
            ack_delay = int'($urandom_range(0, 4)); rel_delay = int'($urandom_range(0, 3)); ready_mode = 1;
            n0 = got_data.size(); d0 = done_cnt;
            do_start(base, len);
            wait_done(500, ok, nc);
            #1;
            n_checks++; if (!ok || got_data.size() - n0 != len) $display("FAIL rand%0d_count got=%0d exp=%0d", it, got_data.size() - n0, len); else n_pass++;
            for (int i = 0; i < len; i++) begin
                n_checks++; if (got_data[n0+i] !== exp_word(base, i) || got_addr[n0+i] !== exp_addr(base, i))
                    $display("FAIL rand%0d_word[%0d] got=%h@%h exp=%h@%h", it, i, got_data[n0+i], got_addr[n0+i], exp_word(base, i), exp_addr(base, i)); else n_pass++;
            end
            n_checks++; if (err !== 1'b0 || done_cnt - d0 != 1) $display("FAIL rand%0d_status got=err%b/done%0d exp=err0/done1", it, err, done_cnt - d0); else n_pass++;
        end
    endtask

    initial begin
        RESET      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        burst_len  = '0;
        ack_delay  = 0;
        rel_delay  = 0;
        slave_mute = 1'b0;
        ready_mode = 0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + i;
        mem[ID_ADDR] = {16'h0000, ID_STATUS};

        test_reset();
        test_burst();
        test_throughput();
        test_backpressure();
        test_timeout();
        test_wrap_id();
        test_zero_len();
        test_start_while_busy();
        test_reset_mid();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
